// File: rtl/divider_128by64_iter.sv
// Iterative radix-2 restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per cycle, with divide-by-zero and quotient-overflow detection.
module divider_128by64_iter #(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [WIDTH-1:0]     quot,
  output logic [WIDTH-1:0]     rem,
  output logic                 busy,
  output logic                 rdy,
  output logic                 dbz,
  output logic                 ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   p_r;
  logic [WIDTH-1:0]   s_r;
  logic [WIDTH-1:0]   dvsr_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   quot_r;
  logic [WIDTH-1:0]   rem_r;
  logic               busy_r;
  logic               rdy_r;
  logic               dbz_r;
  logic               ovf_r;

  logic [WIDTH-1:0]   hi_s;
  logic [WIDTH:0]     t_s;
  logic [WIDTH-1:0]   diff_s;
  logic [WIDTH-1:0]   p_next_s;
  logic               q_bit_s;
  logic [WIDTH-1:0]   s_next_s;
  logic               last_s;

  // One restoring step; the partial remainder stays below the divisor, so W bits hold it
  always_comb begin
    hi_s     = dividend[2*WIDTH-1:WIDTH];
    t_s      = {p_r, s_r[WIDTH-1]};
    diff_s   = t_s[WIDTH-1:0] - dvsr_r;
    p_next_s = t_s[WIDTH-1:0];
    q_bit_s  = 1'b0;
    if (t_s >= {1'b0, dvsr_r}) begin
      p_next_s = diff_s;
      q_bit_s  = 1'b1;
    end else begin
      p_next_s = t_s[WIDTH-1:0];
      q_bit_s  = 1'b0;
    end
    s_next_s = {s_r[WIDTH-2:0], q_bit_s};
    last_s   = (cnt_r == CW'(WIDTH - 1));
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      p_r     <= {WIDTH{1'b0}};
      s_r     <= {WIDTH{1'b0}};
      dvsr_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      quot_r  <= {WIDTH{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      rdy_r   <= 1'b0;
      dbz_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          rdy_r <= 1'b0;
          if (start) begin
            dvsr_r <= divisor;
            dbz_r  <= 1'b0;
            ovf_r  <= 1'b0;
            cnt_r  <= {CW{1'b0}};
            if (divisor == {WIDTH{1'b0}}) begin
              dbz_r   <= 1'b1;
              quot_r  <= {WIDTH{1'b1}};
              rem_r   <= dividend[WIDTH-1:0];
              rdy_r   <= 1'b1;
              state_r <= DONE;
            end else if (hi_s >= divisor) begin
              ovf_r   <= 1'b1;
              quot_r  <= {WIDTH{1'b1}};
              rem_r   <= {WIDTH{1'b0}};
              rdy_r   <= 1'b1;
              state_r <= DONE;
            end else begin
              p_r     <= hi_s;
              s_r     <= dividend[WIDTH-1:0];
              busy_r  <= 1'b1;
              state_r <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          p_r   <= p_next_s;
          s_r   <= s_next_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            quot_r  <= s_next_s;
            rem_r   <= p_next_s;
            busy_r  <= 1'b0;
            rdy_r   <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= CALC;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          rdy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign quot = quot_r;
  assign rem  = rem_r;
  assign busy = busy_r;
  assign rdy  = rdy_r;
  assign dbz  = dbz_r;
  assign ovf  = ovf_r;

endmodule
